// File: rtl/cpu_boot_ctrl_pkg.sv
// Shared definitions for the CPU boot/run sequencer: FSM encoding and default widths
// that match the 8-bit CPU core and its memory.
package cpu_boot_ctrl_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3,
    ST_DONE    = 3'd4
  } boot_state_t;

endpackage

// File: rtl/cpu_boot_ctrl_if.sv
// Image stream (valid/ready) plus CPU memory write port of the boot sequencer.
// The controller side uses the slave modport; the host/memory side uses master.
interface cpu_boot_ctrl_if
  import cpu_boot_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport master (output s_valid, s_data, input s_ready, mem_we, mem_addr, mem_wdata);
  modport slave  (input s_valid, s_data, output s_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/cpu_boot_ctrl_wdog_counter.sv
// Saturating run-cycle counter with a terminal flag raised in the run cycle whose
// increment makes the count reach WDOG_CYCLES.
module cpu_wdog_counter #(
  parameter int CNT_W       = 16,
  parameter int WDOG_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             term_o
);
  localparam logic [CNT_W-1:0] TERM_M1 = CNT_W'(WDOG_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o  = cnt_q;
  assign term_o = en_i && (cnt_q == TERM_M1);
endmodule

// File: rtl/cpu_boot_ctrl.sv
// Boot/run sequencer: holds the CPU in reset while streaming an image into its memory,
// releases it, then watches halt under a watchdog and reports the outcome.
module cpu_boot_ctrl
  import cpu_boot_ctrl_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int WDOG_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              reset_n,
  cpu_boot_ctrl_if.slave    bus,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   load_len,
  input  logic              cpu_halt,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              halted,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count
);
  boot_state_t       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              halted_q, halted_d;
  logic              timeout_q, timeout_d;
  logic              done_q;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              go, accept, term;

  assign go          = start && !abort && (state_q == ST_IDLE || state_q == ST_DONE);
  assign bus.s_ready = (state_q == ST_LOAD);
  assign accept      = bus.s_ready && bus.s_valid;
  assign busy        = (state_q == ST_LOAD) || (state_q == ST_RELEASE) || (state_q == ST_RUN);

  cpu_wdog_counter #(
    .CNT_W       (CNT_W),
    .WDOG_CYCLES (WDOG_CYCLES)
  ) u_wdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (go),
    .en_i    (state_q == ST_RUN),
    .cnt_o   (cycle_count),
    .term_o  (term)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    cpu_reset_d = cpu_reset_q;
    halted_d    = halted_q;
    timeout_d   = timeout_q;
    if (go) begin
      halted_d    = 1'b0;
      timeout_d   = 1'b0;
      addr_d      = '0;
      rem_d       = load_len;
      cpu_reset_d = 1'b1;
      state_d     = (load_len != '0) ? ST_LOAD : ST_RELEASE;
    end else if (abort) begin
      state_d     = ST_IDLE;
      cpu_reset_d = 1'b1;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (accept) begin
            // addr wraps naturally for a full 2**ADDR_W image
            addr_d = addr_q + 1'b1;
            rem_d  = rem_q - 1'b1;
            if (rem_q == (ADDR_W+1)'(1)) state_d = ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          state_d     = ST_RUN;
          cpu_reset_d = 1'b0;
        end
        ST_RUN: begin
          // halt takes priority over a simultaneous watchdog expiry
          if (cpu_halt) begin
            state_d  = ST_DONE;
            halted_d = 1'b1;
          end else if (term) begin
            state_d     = ST_DONE;
            timeout_d   = 1'b1;
            cpu_reset_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      cpu_reset_q <= 1'b1;
      halted_q    <= 1'b0;
      timeout_q   <= 1'b0;
      done_q      <= 1'b0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      cpu_reset_q <= cpu_reset_d;
      halted_q    <= halted_d;
      timeout_q   <= timeout_d;
      done_q      <= (state_d == ST_DONE) && (state_q != ST_DONE);
      we_q        <= accept;
      if (accept) begin
        waddr_q <= addr_q;
        wdata_q <= bus.s_data;
      end
    end
  end

  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = waddr_q;
  assign bus.mem_wdata = wdata_q;
  assign cpu_reset     = cpu_reset_q;
  assign halted        = halted_q;
  assign timeout       = timeout_q;
  assign done          = done_q;
endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// Directed bench for cpu_boot_ctrl: image load, paced stream, watchdog, abort/reset,
// halt/watchdog tie and full-size image wrap.
module tb_cpu_boot_ctrl;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 16;
  localparam int WDOG   = 20;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start, abort, cpu_halt;
  logic [ADDR_W:0]   load_len;
  logic              cpu_reset, busy, done, halted, timeout;
  logic [CNT_W-1:0]  cycle_count;

  int tests = 0;
  int fails = 0;

  logic [ADDR_W-1:0] wr_addr_log [$];
  logic [DATA_W-1:0] wr_data_log [$];
  logic [DATA_W-1:0] exp_d [16];
  logic [DATA_W-1:0] img [6];
  int                log_base;

  cpu_boot_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  cpu_boot_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .WDOG_CYCLES(WDOG)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .start       (start),
    .abort       (abort),
    .load_len    (load_len),
    .cpu_halt    (cpu_halt),
    .cpu_reset   (cpu_reset),
    .busy        (busy),
    .done        (done),
    .halted      (halted),
    .timeout     (timeout),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  // CPU memory side: log every write that lands
  always @(posedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_addr_log.push_back(bus.mem_addr);
      wr_data_log.push_back(bus.mem_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_log(input string tag, input int n);
    int sz;
    sz = wr_addr_log.size();
    check({tag, "_nwrites"}, 32'(sz - log_base), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (log_base + i < sz) begin
        check({tag, "_addr"}, 32'(wr_addr_log[log_base + i]), 32'(i));
        check({tag, "_data"}, 32'(wr_data_log[log_base + i]), 32'(exp_d[i]));
      end
    end
  endtask

  initial begin
    img[0] = 8'h63; img[1] = 8'h73; img[2] = 8'h04;
    img[3] = 8'hE0; img[4] = 8'h02; img[5] = 8'h01;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; cpu_halt = 1'b0; load_len = '0;
    bus.s_valid = 1'b0; bus.s_data = '0;
    tick(); tick();
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_halted", halted, 0);
    check("rst_timeout", timeout, 0);
    check("rst_count", cycle_count, 0);
    check("rst_ready", bus.s_ready, 0);
    check("rst_we", bus.mem_we, 0);
    reset_n = 1'b1;
    tick();

    // Test 1: six-word image, s_valid always high
    for (int i = 0; i < 6; i++) exp_d[i] = img[i];
    log_base = wr_addr_log.size();
    start = 1'b1; load_len = 5'd6;
    tick();
    start = 1'b0;
    check("t1_ready", bus.s_ready, 1);
    check("t1_busy", busy, 1);
    bus.s_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.s_data = img[i];
      tick();
    end
    bus.s_valid = 1'b0;
    check("t1_rel_ready", bus.s_ready, 0);
    check("t1_rel_cpu_reset", cpu_reset, 1);
    check("t1_last_we", bus.mem_we, 1);
    check("t1_last_addr", bus.mem_addr, 5);
    check("t1_last_data", bus.mem_wdata, 8'h01);
    tick();
    check("t1_run_cpu_reset", cpu_reset, 0);
    check("t1_run_count0", cycle_count, 0);
    repeat (4) tick();
    cpu_halt = 1'b1;
    tick();
    cpu_halt = 1'b0;
    check("t1_done", done, 1);
    check("t1_halted", halted, 1);
    check("t1_timeout", timeout, 0);
    check("t1_cpu_reset", cpu_reset, 0);
    check("t1_count", cycle_count, 5);
    check("t1_busy_done", busy, 0);
    tick();
    check("t1_done_pulse", done, 0);
    check("t1_count_frozen", cycle_count, 5);
    check_log("t1", 6);

    // Test 2: same image, s_valid every other cycle
    log_base = wr_addr_log.size();
    start = 1'b1; load_len = 5'd6;
    tick();
    start = 1'b0;
    check("t2_halted_clr", halted, 0);
    check("t2_count_clr", cycle_count, 0);
    begin
      int idx;
      logic sv;
      idx = 0; sv = 1'b1;
      while (idx < 6) begin
        bus.s_valid = sv;
        bus.s_data  = sv ? img[idx] : 8'hAA;
        tick();
        check("t2_we_follows_valid", bus.mem_we, sv);
        if (sv) idx++;
        sv = ~sv;
      end
    end
    bus.s_valid = 1'b0;
    tick();
    check("t2_run_cpu_reset", cpu_reset, 0);
    cpu_halt = 1'b1;
    tick();
    cpu_halt = 1'b0;
    check("t2_done", done, 1);
    check("t2_count", cycle_count, 1);
    check_log("t2", 6);

    // Test 4: load_len=0 reruns existing memory; start during RUN ignored
    log_base = wr_addr_log.size();
    start = 1'b1; load_len = 5'd0;
    tick();
    start = 1'b0;
    check("t4_rel_busy", busy, 1);
    check("t4_rel_ready", bus.s_ready, 0);
    check("t4_rel_cpu_reset", cpu_reset, 1);
    tick();
    check("t4_run_cpu_reset", cpu_reset, 0);
    start = 1'b1; load_len = 5'd5;
    tick();
    start = 1'b0;
    check("t4_ign_busy", busy, 1);
    check("t4_ign_ready", bus.s_ready, 0);
    check("t4_ign_cpu_reset", cpu_reset, 0);
    tick();
    cpu_halt = 1'b1;
    tick();
    cpu_halt = 1'b0;
    check("t4_done", done, 1);
    check("t4_halted", halted, 1);
    check("t4_count", cycle_count, 3);
    check_log("t4", 0);

    // Test 3: single 00 word, no halt, watchdog expires at 20
    exp_d[0] = 8'h00;
    log_base = wr_addr_log.size();
    start = 1'b1; load_len = 5'd1;
    tick();
    start = 1'b0;
    bus.s_valid = 1'b1; bus.s_data = 8'h00;
    tick();
    bus.s_valid = 1'b0;
    tick();
    repeat (19) tick();
    check("t3_pre_busy", busy, 1);
    check("t3_pre_count", cycle_count, 19);
    check("t3_pre_timeout", timeout, 0);
    check("t3_pre_done", done, 0);
    tick();
    check("t3_done", done, 1);
    check("t3_timeout", timeout, 1);
    check("t3_halted", halted, 0);
    check("t3_cpu_reset", cpu_reset, 1);
    check("t3_count", cycle_count, 20);
    tick();
    check("t3_done_pulse", done, 0);
    check("t3_count_frozen", cycle_count, 20);
    check_log("t3", 1);

    // Test 6: halt on the watchdog terminal cycle; start during RUN ignored
    start = 1'b1; load_len = 5'd0;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (18) tick();
    check("t6_pre_count", cycle_count, 19);
    check("t6_pre_busy", busy, 1);
    cpu_halt = 1'b1;
    tick();
    cpu_halt = 1'b0;
    check("t6_done", done, 1);
    check("t6_halted", halted, 1);
    check("t6_timeout", timeout, 0);
    check("t6_cpu_reset", cpu_reset, 0);
    check("t6_count", cycle_count, 20);

    // Test 5a: abort after three words in LOAD
    for (int i = 0; i < 6; i++) exp_d[i] = img[i];
    log_base = wr_addr_log.size();
    start = 1'b1; load_len = 5'd6;
    tick();
    start = 1'b0;
    bus.s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.s_data = img[i];
      tick();
    end
    bus.s_valid = 1'b0;
    abort = 1'b1;
    check("t5a_inflight_we", bus.mem_we, 1);
    check("t5a_inflight_addr", bus.mem_addr, 2);
    tick();
    abort = 1'b0;
    check("t5a_busy", busy, 0);
    check("t5a_ready", bus.s_ready, 0);
    check("t5a_cpu_reset", cpu_reset, 1);
    check("t5a_done", done, 0);
    check("t5a_halted", halted, 0);
    check("t5a_timeout", timeout, 0);
    tick();
    check("t5a_no_done", done, 0);
    check_log("t5a", 3);

    // Test 5b: reset_n low during RUN
    start = 1'b1; load_len = 5'd0;
    tick();
    start = 1'b0;
    tick();
    repeat (3) tick();
    check("t5b_pre_count", cycle_count, 3);
    check("t5b_pre_cpu_reset", cpu_reset, 0);
    reset_n = 1'b0;
    #1;
    check("t5b_cpu_reset", cpu_reset, 1);
    check("t5b_busy", busy, 0);
    check("t5b_count", cycle_count, 0);
    check("t5b_done", done, 0);
    check("t5b_halted", halted, 0);
    tick();
    reset_n = 1'b1;
    tick();
    check("t5b_idle_busy", busy, 0);

    // Full 2**ADDR_W image: address wraps, exactly 16 writes
    for (int i = 0; i < 16; i++) exp_d[i] = 8'(i * 17 + 1);
    log_base = wr_addr_log.size();
    start = 1'b1; load_len = 5'd16;
    tick();
    start = 1'b0;
    bus.s_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.s_data = exp_d[i];
      tick();
    end
    bus.s_valid = 1'b0;
    check("wrap_rel_ready", bus.s_ready, 0);
    check("wrap_last_addr", bus.mem_addr, 15);
    tick();
    tick();
    check("wrap_no_extra_we", bus.mem_we, 0);
    cpu_halt = 1'b1;
    tick();
    cpu_halt = 1'b0;
    check("wrap_done", done, 1);
    check_log("wrap", 16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
